lsu_multicycle: RTL and testbench

- Parametrised load/store unit for the next-generation multi-cycle RISC-V datapath; replaces the fixed word-only load path.
- Computes the effective address as base + imm and runs the byte/half/word (and, at XLEN=64, double) access against a data memory with a variable-latency req/ack handshake.
- Returns sign- or zero-extended load data, or store completion, with alignment, illegal-op and timeout status.

---
 rtl/lsu_multicycle.sv | 258 +++++++++++++++++++++++++
 tb/tb_lsu_multicycle.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: base+imm address generation, byte-lane steering,
// variable-latency req/ack memory handshake with timeout, and extended load return.
module lsu_multicycle #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_base,
  input  logic [XLEN-1:0]     req_imm,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_wb,
  output logic                resp_misaligned,
  output logic                resp_illegal,
  output logic                resp_fault
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int CW   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  // Captured request and access status.
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic            load_q;
  logic [4:0]      rd_q;
  logic            illegal_q;
  logic            misaligned_q;
  logic            fault_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] wdata_q;
  logic [BEW-1:0]  be_q;
  logic [CW-1:0]   wait_cnt;

  logic [XLEN-1:0] req_addr;
  logic [OFFW-1:0] req_off;
  logic            req_illegal;
  logic            req_misaligned;
  logic            accept;
  logic            wait_done;

  assign req_addr = req_base + req_imm;
  assign req_off  = req_addr[OFFW-1:0];
  assign accept   = (state == S_IDLE) && req_valid;
  assign wait_done = (wait_cnt == CW'(MAX_WAIT - 1));

  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        3'b011, 3'b110:                         ok = (XLEN == 64);
        default:                                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        3'b011:                 ok = (XLEN == 64);
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // funct3[1:0] encodes log2 of the access size for every legal opcode.
  function automatic logic addr_misaligned(input logic [1:0] size, input logic [2:0] a);
    logic bad;
    case (size)
      2'b01:   bad = a[0];
      2'b10:   bad = |a[1:0];
      2'b11:   bad = |a[2:0];
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  assign req_illegal    = !f3_legal(req_load, req_funct3);
  assign req_misaligned = !req_illegal && addr_misaligned(req_funct3[1:0], req_addr[2:0]);

  // Store lane steering: size-wide slice moved to its byte offset.
  logic [XLEN-1:0] st_lane;
  logic [BEW-1:0]  st_be_base;
  logic [XLEN-1:0] st_wdata;
  logic [BEW-1:0]  st_be;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    st_lane    = '0;
    st_be_base = '0;
    case (req_funct3[1:0])
      2'b00: begin
        st_lane    = XLEN'(req_wdata[7:0]);
        st_be_base = BEW'(1);
      end
      2'b01: begin
        st_lane    = XLEN'(req_wdata[15:0]);
        st_be_base = BEW'(3);
      end
      2'b10: begin
        st_lane    = XLEN'(req_wdata[31:0]);
        st_be_base = BEW'(4'hF);
      end
      2'b11: begin
        st_lane    = req_wdata;
        st_be_base = '1;
      end
    endcase
    st_wdata = st_lane << {req_off, 3'b000};
    st_be    = st_be_base << req_off;
  end

  // Load extraction from the captured read word.
  logic [XLEN-1:0] ld_lane;
  logic [XLEN-1:0] ld_data;

  always_comb begin
    ld_lane = rdata_q >> {addr_q[OFFW-1:0], 3'b000};
    ld_data = ld_lane;
    case (funct3_q)
      3'b000:  ld_data = XLEN'($signed(ld_lane[7:0]));
      3'b001:  ld_data = XLEN'($signed(ld_lane[15:0]));
      3'b010:  ld_data = XLEN'($signed(ld_lane[31:0]));
      3'b100:  ld_data = XLEN'(ld_lane[7:0]);
      3'b101:  ld_data = XLEN'(ld_lane[15:0]);
      3'b110:  ld_data = XLEN'(ld_lane[31:0]);
      default: ld_data = ld_lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (req_illegal || req_misaligned) ? S_ERR : S_MEM;
      S_MEM:  if (mem_ack || wait_done) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      S_ERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Captured request, read data and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: these are plain control/data registers, not a storage array, so
    // they take the async reset and come up as a known all-zero request.
    if (!rst) begin
      addr_q       <= '0;
      funct3_q     <= '0;
      load_q       <= 1'b0;
      rd_q         <= '0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      wait_cnt     <= '0;
    end else if (accept) begin
      addr_q       <= req_addr;
      funct3_q     <= req_funct3;
      load_q       <= req_load;
      rd_q         <= req_rd;
      illegal_q    <= req_illegal;
      misaligned_q <= req_misaligned;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      wdata_q      <= req_load ? '0 : st_wdata;
      be_q         <= st_be;
      wait_cnt     <= '0;
    end else if (state == S_MEM) begin
      if (mem_ack) begin
        if (load_q) rdata_q <= mem_rdata;
        wait_cnt <= '0;
      end else if (wait_done) begin
        fault_q  <= 1'b1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Outputs decoded from state; reset drops them immediately.
  always_comb begin
    req_ready       = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_be          = '0;
    resp_valid      = 1'b0;
    resp_data       = '0;
    resp_rd         = '0;
    resp_wb         = 1'b0;
    resp_misaligned = 1'b0;
    resp_illegal    = 1'b0;
    resp_fault      = 1'b0;
    case (state)
      S_IDLE: req_ready = 1'b1;
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = !load_q;
        mem_addr  = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
        mem_wdata = wdata_q;
        mem_be    = be_q;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        resp_fault = fault_q;
        resp_wb    = load_q && !fault_q;
        resp_data  = (load_q && !fault_q) ? ld_data : '0;
      end
      S_ERR: begin
        resp_valid      = 1'b1;
        resp_rd         = rd_q;
        resp_misaligned = misaligned_q;
        resp_illegal    = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_multicycle.sv
// Bench for lsu_multicycle: XLEN=32/MAX_WAIT=4 vector table with a response
// scoreboard, plus hand sequences for reset mid-access, busy requests and XLEN=64.
module tb_lsu_multicycle;

  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // XLEN=32 instance
  logic        req_valid = 0, req_load = 0, mem_ack = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_base = 0, req_imm = 0, req_wdata = 0, mem_rdata = 0;
  logic [4:0]  req_rd = 0;
  logic        req_ready, mem_req, mem_we, resp_valid, resp_wb;
  logic        resp_misaligned, resp_illegal, resp_fault;
  logic [31:0] mem_addr, mem_wdata, resp_data;
  logic [3:0]  mem_be;
  logic [4:0]  resp_rd;

  lsu_multicycle #(.XLEN(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_wb(resp_wb),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal), .resp_fault(resp_fault)
  );

  // XLEN=64 instance
  logic        x_req_valid = 0, x_req_load = 0, x_mem_ack = 0;
  logic [2:0]  x_req_funct3 = 0;
  logic [63:0] x_req_base = 0, x_req_imm = 0, x_req_wdata = 0, x_mem_rdata = 0;
  logic [4:0]  x_req_rd = 0;
  logic        x_req_ready, x_mem_req, x_mem_we, x_resp_valid, x_resp_wb;
  logic        x_resp_misaligned, x_resp_illegal, x_resp_fault;
  logic [63:0] x_mem_addr, x_mem_wdata, x_resp_data;
  logic [7:0]  x_mem_be;
  logic [4:0]  x_resp_rd;

  lsu_multicycle #(.XLEN(64), .MAX_WAIT(16)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(x_req_valid), .req_ready(x_req_ready), .req_load(x_req_load),
    .req_funct3(x_req_funct3), .req_base(x_req_base), .req_imm(x_req_imm),
    .req_wdata(x_req_wdata), .req_rd(x_req_rd),
    .mem_req(x_mem_req), .mem_we(x_mem_we), .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata),
    .mem_be(x_mem_be), .mem_ack(x_mem_ack), .mem_rdata(x_mem_rdata),
    .resp_valid(x_resp_valid), .resp_data(x_resp_data), .resp_rd(x_resp_rd), .resp_wb(x_resp_wb),
    .resp_misaligned(x_resp_misaligned), .resp_illegal(x_resp_illegal), .resp_fault(x_resp_fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        load;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          ack_at;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    logic        e_wb;
    logic        e_mis;
    logic        e_ill;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wb;
    logic        mis;
    logic        ill;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  // Response monitor: pops one expectation per resp_valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: resp_valid=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_rd", resp_rd, e.rd);
        check("resp_wb", resp_wb, e.wb);
        check("resp_misaligned", resp_misaligned, e.mis);
        check("resp_illegal", resp_illegal, e.ill);
        check("resp_fault", resp_fault, e.fault);
        check("resp_cycle", cyc, e.cyc);
      end
    end else begin
      check("resp_idle_zero",
            {resp_data, resp_rd, resp_wb, resp_misaligned, resp_illegal, resp_fault}, '0);
    end
  end

  task automatic run_vec(input vec_t v);
    int   req_cnt;
    int   exp_req;
    int   lat;
    logic err;
    exp_t e;
    err     = v.e_mis || v.e_ill;
    exp_req = err ? 0 : (v.e_fault ? MW : v.ack_at);
    lat     = err ? 1 : (v.e_fault ? MW + 1 : v.ack_at + 1);
    @(negedge clk);
    check("req_ready", req_ready, 1'b1);
    req_valid  = 1'b1;
    req_load   = v.load;
    req_funct3 = v.f3;
    req_base   = v.base;
    req_imm    = v.imm;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    e.data  = v.e_data;
    e.rd    = v.rd;
    e.wb    = v.e_wb;
    e.mis   = v.e_mis;
    e.ill   = v.e_ill;
    e.fault = v.e_fault;
    e.cyc   = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_cnt = 0;
    for (int k = 1; k <= MW + 3; k++) begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (k == 1 && exp_req > 0) begin
        check("mem_addr", mem_addr, v.e_addr);
        check("mem_be", mem_be, v.e_be);
        check("mem_we", mem_we, !v.load);
        check("mem_wdata", mem_wdata, v.e_wdata);
      end
      if (k == v.ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rdata;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    check("mem_req_cycles", req_cnt, exp_req);
    check("resp_missing", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run64(input logic load, input logic [2:0] f3, input logic [63:0] base,
                       input logic [63:0] wdata, input logic [63:0] rdata,
                       input logic [63:0] e_addr, input logic [7:0] e_be,
                       input logic [63:0] e_wdata, input logic [63:0] e_data);
    @(negedge clk);
    x_req_valid  = 1'b1;
    x_req_load   = load;
    x_req_funct3 = f3;
    x_req_base   = base;
    x_req_imm    = 64'h8;
    x_req_wdata  = wdata;
    x_req_rd     = 5'd17;
    @(posedge clk);
    #1 x_req_valid = 1'b0;
    @(negedge clk);
    check("x_mem_req", x_mem_req, 1'b1);
    check("x_mem_addr", x_mem_addr, e_addr);
    check("x_mem_be", x_mem_be, e_be);
    if (!load) check("x_mem_wdata", x_mem_wdata, e_wdata);
    x_mem_ack   = 1'b1;
    x_mem_rdata = rdata;
    @(posedge clk);
    #1 x_mem_ack = 1'b0;
    @(negedge clk);
    check("x_resp_valid", x_resp_valid, 1'b1);
    check("x_resp_data", x_resp_data, e_data);
    check("x_resp_wb", x_resp_wb, load);
    check("x_resp_rd", x_resp_rd, 5'd17);
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 3, 32'hDEADBEEF,
                          32'h104, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b000, 32'h200, 32'h3, 32'h0, 5'd6, 1, 32'h80FF0011,
                          32'h200, 4'h8, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b100, 32'h200, 32'h3, 32'h0, 5'd7, 2, 32'h80FF0011,
                          32'h200, 4'h8, 32'h0, 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b001, 32'h200, 32'h2, 32'h0, 5'd8, 2, 32'h80FF0011,
                          32'h200, 4'hC, 32'h0, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b101, 32'h200, 32'h0, 32'h0, 5'd9, 1, 32'h80FF0011,
                          32'h200, 4'h3, 32'h0, 32'h00000011, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'h10, 32'h2, 32'hAAAA5678, 5'd1, 1, 32'h0,
                          32'h10, 4'hC, 32'h56780000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'b000, 32'h302, 32'hFFFFFFFF, 32'h123456AB, 5'd2, 2, 32'h0,
                          32'h300, 4'h2, 32'h0000AB00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'b010, 32'h0, 32'h8, 32'hCAFEF00D, 5'd3, 4, 32'h0,
                          32'h8, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd4, 1, 32'h13579BDF,
                          32'h4, 4'hF, 32'h0, 32'h13579BDF, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'h100, 32'h2, 32'h0, 5'd10, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b011, 32'h100, 32'h1, 32'h0, 5'd11, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'b001, 32'h10, 32'h3, 32'h1234, 5'd12, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b0, 3'b110, 32'h100, 32'h2, 32'h1234, 5'd13, 0, 32'h0,
                          32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 5'd14, 6, 32'h55555555,
                          32'h40, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 3'b010, 32'h40, 32'h4, 32'h0, 5'd15, 1, 32'h0BADF00D,
                          32'h44, 4'hF, 32'h0, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 1'b0});

    // Reset state
    #3;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_be", mem_be, 4'h0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_x_req_ready", x_req_ready, 1'b1);
    check("rst_x_mem_req", x_mem_req, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // req_valid held high while busy must not start a second access.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h500; req_imm = 32'h0; req_rd = 5'd20;
    e = '{32'h00C0FFEE, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, cyc + 3};
    sb.push_back(e);
    @(posedge clk);
    #1 req_rd = 5'd21; req_funct3 = 3'b111;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h00C0FFEE;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_resp_missing", sb.size(), 0);
    sb.delete();

    // Reset while in MEM: outputs drop at once and no response follows.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h600; req_imm = 32'h0; req_rd = 5'd22;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_mem_req_before", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (MW + 3) @(negedge clk);
    check("post_rst_req_ready", req_ready, 1'b1);

    // XLEN=64 accesses (imm fixed at 8)
    run64(1'b1, 3'b011, 64'h0, 64'h0, 64'h8000000000000001,
          64'h8, 8'hFF, 64'h0, 64'h8000000000000001);
    run64(1'b1, 3'b010, 64'h4, 64'h0, 64'h8000000000000000,
          64'h8, 8'hF0, 64'h0, 64'hFFFFFFFF80000000);
    run64(1'b1, 3'b110, 64'h4, 64'h0, 64'h8000000000000000,
          64'h8, 8'hF0, 64'h0, 64'h0000000080000000);
    run64(1'b1, 3'b000, 64'h7, 64'h0, 64'h8000000000000000,
          64'h8, 8'h80, 64'h0, 64'hFFFFFFFFFFFFFF80);
    run64(1'b0, 3'b001, 64'h2, 64'h0000_0000_0000_BEEF, 64'h0,
          64'h8, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
